coproc_arbiter: RTL
===================

COPROC_ARBITER -- requirements
Module: coproc_arbiter

Interface
REQ-001 Parameter TIMEOUT, default 255: the maximum number of WAIT cycles allowed for cp_ready before the operation is aborted; legal range 1..255.
REQ-002 clk  in  1  single system clock; all logic updates on its rising edge.
REQ-003 rst  in  1  reset, synchronous, active-high.
REQ-004 req0 / req1  in  1 each  level request from requester 0 / 1; held high until that requester's done pulse.
REQ-005 op0 / op1  in  3 each  opcode from requester 0 / 1: 000 add, 001 sub, 010 matrix multiply, 011 scalar multiply, 100 determinant, 101 transpose, 110 opposite, 111 illegal.
REQ-006 size0 / size1  in  2 each  matrix size from requester 0 / 1: 00 = 2x2, 01 = 3x3, 10 = 4x4, 11 = 5x5.
REQ-007 gnt0 / gnt1  out  1 each  high from ISSUE through RESP while the coprocessor is owned by that requester; never both high.
REQ-008 done0 / done1  out  1 each  one-cycle completion pulse to the owning requester.
REQ-009 ovf_out  out  1  coprocessor overflow for the completed operation; valid only while done0 or done1 is high.
REQ-010 err_out  out  1  error flag (illegal opcode or timeout); valid only while done0 or done1 is high.
REQ-011 busy  out  1  high in every state except IDLE.
REQ-012 cp_start  out  1  one-cycle start pulse to the coprocessor.
REQ-013 cp_opcode  out  3  latched opcode driven to the coprocessor.
REQ-014 cp_msize  out  2  latched size driven to the coprocessor.
REQ-015 cp_ready  in  1  coprocessor result-ready pulse.
REQ-016 cp_overflow  in  1  coprocessor overflow flag; sampled in the same cycle as cp_ready.

Function
REQ-017 The FSM SHALL have four states: IDLE, ISSUE, WAIT, RESP; all other encodings SHALL go to IDLE on the next cycle.
REQ-018 In IDLE with exactly one req high, the arbiter SHALL select that requester, latch its op/size, assert its gnt, and go to ISSUE next cycle.
REQ-019 In IDLE with both req high, the arbiter SHALL select the requester not served last (round-robin); the last-served pointer SHALL update at each selection.
REQ-020 In ISSUE with a legal opcode, cp_start SHALL be 1 for exactly that cycle, with cp_opcode/cp_msize already valid; the next state SHALL be WAIT.
REQ-021 In ISSUE with opcode 111, cp_start SHALL stay 0; the error flag SHALL be latched to 1 and the next state SHALL be RESP.
REQ-022 cp_ready SHALL be ignored in every state except WAIT.
REQ-023 In WAIT, an 8-bit counter SHALL start at 0 on entry and increment each cycle.
REQ-024 In WAIT, cp_ready=1 SHALL latch cp_overflow, set the error flag to 0, and go to RESP.
REQ-025 In WAIT, if the counter reaches TIMEOUT-1 with no cp_ready, the arbiter SHALL set the error flag to 1, set the overflow flag to 0, and go to RESP.
REQ-026 In RESP, the owner's done SHALL pulse for one cycle with ovf_out/err_out valid; gnt SHALL drop and the state SHALL return to IDLE next cycle.
REQ-027 cp_opcode/cp_msize SHALL hold their latched values from ISSUE through RESP; req/op/size changes after latching SHALL be ignored.
REQ-028 Latency: req sampled in IDLE at cycle N gives cp_start at N+1; cp_ready at cycle M gives done at M+1; the earliest next grant is at the cycle after done.
REQ-029 A requester that keeps req high after its done SHALL be treated as a new request, subject to round-robin.

Reset
REQ-030 With rst=1 at a clock edge, the arbiter SHALL go to IDLE and the pointer SHALL reset so that requester 0 wins the first tie.
REQ-031 With rst=1 at a clock edge, the counter and latched fields SHALL be cleared to 0.
REQ-032 With rst=1 at a clock edge, every output SHALL be 0: gnt0, gnt1, done0, done1, ovf_out, err_out, busy, cp_start, cp_opcode, cp_msize.
REQ-033 Reset during ISSUE, WAIT or RESP SHALL abort the operation with no done pulse; a cp_ready arriving after reset SHALL be ignored.

Verification
REQ-034 req0=1, op0=000, size0=11 -> gnt0 and cp_start one cycle later with cp_opcode=000, cp_msize=11; cp_ready=1, cp_overflow=1 three cycles later -> done0 one cycle after that with ovf_out=1, err_out=0.
REQ-035 req0 and req1 rise in the same cycle after reset -> requester 0 served first; with both held, requester 1 is served next, then requester 0 (alternation).
REQ-036 req1=1, op1=111 -> gnt1, no cp_start, done1 two cycles after the grant decision with err_out=1.
REQ-037 TIMEOUT=4, req0=1, op0=010, cp_ready never asserted -> done0 with err_out=1, ovf_out=0 after 4 WAIT cycles; busy then drops.
REQ-038 rst=1 in WAIT, then cp_ready=1 -> no done pulse, all outputs 0; the next req1 is served normally.
REQ-039 cp_ready pulsed in IDLE and in ISSUE -> ignored; completion occurs only on the cp_ready seen in WAIT.

Source files
------------

// File: rtl/coproc_arbiter.sv
// Two-requester round-robin front end for the matrix coprocessor: grants one
// requester at a time, issues its latched command, waits for cp_ready or timeout.
module coproc_arbiter #(
    parameter int TIMEOUT = 255
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       req0,
    input  logic       req1,
    input  logic [2:0] op0,
    input  logic [2:0] op1,
    input  logic [1:0] size0,
    input  logic [1:0] size1,
    output logic       gnt0,
    output logic       gnt1,
    output logic       done0,
    output logic       done1,
    output logic       ovf_out,
    output logic       err_out,
    output logic       busy,
    output logic       cp_start,
    output logic [2:0] cp_opcode,
    output logic [1:0] cp_msize,
    input  logic       cp_ready,
    input  logic       cp_overflow
);

    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;

    typedef struct packed {
        logic [2:0] op;
        logic [1:0] size;
    } cmd_t;

    localparam logic [7:0] TMO_LAST   = 8'(TIMEOUT - 1);
    localparam logic [2:0] OP_ILLEGAL = 3'b111;

    state_t     state, state_nxt;
    cmd_t       cmd;
    logic       owner;
    logic       last;
    logic [7:0] cnt;
    logic       ovf_q;
    logic       err_q;
    logic       pick_valid;
    logic       pick;
    logic       illegal;
    logic       tmo_hit;

    // On a tie the requester not served last wins; a lone request always wins.
    assign pick_valid = req0 | req1;
    assign pick       = (req0 & req1) ? ~last : req1;
    assign illegal    = (cmd.op == OP_ILLEGAL);
    assign tmo_hit    = (cnt == TMO_LAST);

    always_ff @(posedge clk) begin
        if (rst) state <= IDLE;
        else     state <= state_nxt;
    end

    always_comb begin
        state_nxt = IDLE;
        busy      = 1'b0;
        gnt0      = 1'b0;
        gnt1      = 1'b0;
        done0     = 1'b0;
        done1     = 1'b0;
        ovf_out   = 1'b0;
        err_out   = 1'b0;
        cp_start  = 1'b0;
        cp_opcode = cmd.op;
        cp_msize  = cmd.size;
        case (state)
            IDLE:    state_nxt = pick_valid ? ISSUE : IDLE;
            ISSUE: begin
                state_nxt = illegal ? RESP : WAIT;
                cp_start  = ~illegal;
            end
            WAIT:    state_nxt = (cp_ready || tmo_hit) ? RESP : WAIT;
            RESP: begin
                state_nxt = IDLE;
                done0     = ~owner;
                done1     = owner;
                ovf_out   = ovf_q;
                err_out   = err_q;
            end
            default: state_nxt = IDLE;
        endcase
        if (state != IDLE) begin
            busy = 1'b1;
            gnt0 = ~owner;
            gnt1 = owner;
        end
    end

    // last resets to 1 so requester 0 takes the first tie.
    always_ff @(posedge clk) begin
        if (rst) begin
            cmd   <= '0;
            owner <= 1'b0;
            last  <= 1'b1;
            cnt   <= 8'd0;
            ovf_q <= 1'b0;
            err_q <= 1'b0;
        end else begin
            case (state)
                IDLE: begin
                    if (pick_valid) begin
                        owner <= pick;
                        last  <= pick;
                        cmd   <= pick ? {op1, size1} : {op0, size0};
                        ovf_q <= 1'b0;
                        err_q <= 1'b0;
                    end
                end
                ISSUE: begin
                    cnt <= 8'd0;
                    if (illegal) err_q <= 1'b1;
                end
                WAIT: begin
                    cnt <= cnt + 8'd1;
                    if (cp_ready) begin
                        ovf_q <= cp_overflow;
                        err_q <= 1'b0;
                    end else if (tmo_hit) begin
                        ovf_q <= 1'b0;
                        err_q <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

endmodule
